// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmitter and its line
// synchronizers.
//   ps2_state_e : transmitter state machine states
//   DATA_BITS   : data bits per frame
//   STOP_EDGE   : device clock falling edge that carries the stop bit
//   ACK_EDGE    : device clock falling edge on which the device acknowledges
//   odd_parity(): parity bit that makes the count of ones in data+parity odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_EDGE = 10;
  localparam int ACK_EDGE  = 11;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync -- brings one asynchronous open-drain PS/2 line into the clk
// domain and flags its falling edges.
//   clk     : system clock
//   rst     : synchronous, active-high reset (flops preset to the idle-high level)
//   line_i  : raw sensed line level (asynchronous)
//   level_o : synchronized line level
//   fall_o  : high for one cycle when the synchronized level goes 1 -> 0
// A pin change is registered by the consumer on the third clk edge after it.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Presetting to 1 matches the released bus, so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter for a single command byte.
// Performs the request-to-send sequence, shifts start/data/parity/stop on the
// device's SCL falling edges and checks the device acknowledge.
//   clk, rst        : system clock, synchronous active-high reset
//   data_in, send   : command byte and start request (taken only when idle)
//   busy            : transaction in progress
//   done, ack_err   : one-cycle completion pulse; ack_err=1 means no ACK or timeout
//   SCL_in, SDA_in  : sensed PS/2 clock/data lines (asynchronous)
//   SCL_oe, SDA_oe  : 1 pulls the corresponding open-drain line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SCL_oe,
  output logic       SDA_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e           state_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 parity_q;
  logic [3:0]           bit_cnt_q;
  logic [INH_W-1:0]     inh_cnt_q;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic                 scl_oe_q;
  logic                 sda_oe_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ack_err_q;

  logic                 scl_level;
  logic                 scl_fall;
  logic                 sda_level;
  logic                 sda_fall_unused;  // the transmitter never needs SDA edges
  logic [3:0]           edge_num;         // number of the SCL falling edge being handled

  ps2_line_sync u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (SCL_in),
    .level_o (scl_level),
    .fall_o  (scl_fall)
  );

  ps2_line_sync u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (SDA_in),
    .level_o (sda_level),
    .fall_o  (sda_fall_unused)
  );

  assign edge_num = bit_cnt_q + 4'd1;

  // NOTE: every state register uses <= so all of them update together from
  // the values of the previous cycle, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the frame data register is cleared too; it is a handful of flops,
      // not a memory, so resetting it is free and keeps the state fully known.
      state_q   <= IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (send) begin
            data_q    <= data_in;
            parity_q  <= odd_parity(data_in);
            busy_q    <= 1'b1;
            ack_err_q <= 1'b0;
            inh_cnt_q <= '0;
            scl_oe_q  <= 1'b1;
            state_q   <= INHIBIT;
          end
        end

        INHIBIT: begin
          // SCL went low on the accepting edge, so it stays low exactly
          // INHIBIT_CYCLES cycles; clock release and start bit change together.
          if (inh_cnt_q == INH_LAST) begin
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b1;
            state_q  <= REQ;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end

        REQ: begin
          bit_cnt_q <= '0;
          tmo_cnt_q <= '0;
          state_q   <= SHIFT;
        end

        SHIFT, ACK, WAIT_IDLE: begin
          if (scl_fall) begin
            tmo_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end

          if (!scl_fall && tmo_cnt_q == TMO_LAST) begin
            // Device went silent: let go of both lines and report failure.
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            ack_err_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            case (state_q)
              SHIFT: begin
                if (scl_fall) begin
                  bit_cnt_q <= edge_num;
                  if (edge_num <= 4'(DATA_BITS)) begin
                    sda_oe_q <= ~data_q[bit_cnt_q[2:0]];
                  end else if (edge_num == 4'(DATA_BITS + 1)) begin
                    sda_oe_q <= ~parity_q;
                  end else if (edge_num == 4'(STOP_EDGE)) begin
                    sda_oe_q <= 1'b0;
                    state_q  <= ACK;
                  end
                end
              end

              ACK: begin
                if (scl_fall && edge_num == 4'(ACK_EDGE)) begin
                  bit_cnt_q <= edge_num;
                  ack_err_q <= sda_level;
                  state_q   <= WAIT_IDLE;
                end
              end

              WAIT_IDLE: begin
                if (scl_level && sda_level) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end
              end

              default: ;
            endcase
          end
        end

        DONE: begin
          // A send seen here is dropped; it is taken next cycle if still high.
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign SCL_oe  = scl_oe_q;
  assign SDA_oe  = sda_oe_q;

endmodule
